retire_trace_buf: RTL and testbench
===================================

Name: retire_trace_buf

Overview:
- Captures one retirement record per cycle from the MEM/WB boundary of the non-forwarding core.
- Classifies each record (branch/load/store/jump/default) and tags it with a sequence number.
- Buffers records in a small FIFO.
- Presents records on a valid/ready trace port, so the log writer or a debug port can drain them at its own pace.
- Lossy by default. Dropped records are counted and remain visible as sequence gaps.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of overflow counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- retire_vld_i  in  1  MEM/WB instruction retires this cycle (core o_insn_vld)
- retire_pc_i  in  32  MEMWB pc
- retire_instr_i  in  32  MEMWB instruction word
- retire_wb_data_i  in  32  writeback data (WB_rd_data)
- retire_alu_i  in  32  MEMWB ALU result (load/store address)
- retire_ldata_i  in  32  MEMWB LSU read data
- retire_sdata_i  in  32  MEMWB store data
- trc_vld_o  out  1  head record valid
- trc_rdy_i  in  1  consumer accepts head record
- trc_seq_o  out  32  retirement sequence number
- trc_pc_o  out  32  pc
- trc_instr_o  out  32  instruction
- trc_rd_o  out  5  instr[11:7]
- trc_data_o  out  32  selected data field
- trc_addr_o  out  12  ls address, alu[11:0]
- trc_class_o  out  3  0 default, 1 branch, 2 load, 3 store, 4 jump
- trc_size_o  out  3  one-hot: 001 word, 010 half, 100 byte, 000 non-LS
- trc_mem_o  out  3  one-hot region: [0] alu[15:13]==3'b001, [1] alu[15:6]==10'b0111000000, [2] alu[15:5]==11'b01111000000
- ovf_cnt_o  out  CNT_W  dropped-record count, saturating
- full_o  out  1  FIFO full
- stall_o  out  1  backpressure request (TRACE_STALL_EN only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync deassert inside the block): pointers=0, count=0, seq=0, ovf_cnt_o=0; trc_vld_o=0, full_o=0, stall_o=0. Payload outputs are don't-care but must read as 0 after reset.
- Classification is combinational on retire inputs, with priority branch > load > store > jump > default.
  - jump = JAL, JALR or AUIPC.
  - Data select: load→ldata, store→sdata, jump/default→wb_data, branch→0.
- Record = {seq, pc, instr, rd, data, addr, class, size, mem}.
- Push condition: retire_vld_i && (!full || pop), where pop = trc_vld_o && trc_rdy_i.
  - Pushing into a full FIFO while popping the same cycle is legal; count is unchanged.
- Drop: retire_vld_i && full && !pop.
  - The record is discarded.
  - ovf_cnt_o increments and saturates at all-ones.
- seq increments on every retire_vld_i cycle, whether pushed or dropped, and wraps mod 2^32.
- Latency: a record pushed in cycle N is visible at trc_* in cycle N+1 at the earliest. There is no same-cycle bypass when empty.
- Handshake:
  - trc_vld_o = count!=0.
  - The head stays stable until accepted.
  - trc_rdy_i while trc_vld_o=0 has no effect.
- Pointers wrap modulo DEPTH. full_o = count==DEPTH.
- Reset mid-operation discards all buffered records and the counters.

Optional Feature:
- Macro: TRACE_STALL_EN.
- Defined:
  - stall_o = (count ≥ DEPTH-1) && !pop, registered one cycle early so the core can freeze retirement before full.
  - Drops still counted if retire arrives while full (protocol violation by core).
- Undefined: stall_o tied 0; lossy behaviour as above.

Decomposition:
- Shared package trace_pkg holds:
  - trace_class_e enum;
  - size one-hot constants (SZ_W/SZ_H/SZ_B);
  - region match constants;
  - trace_rec_t packed struct.
- Instruction masks/expected values come from the existing package_decode.
- Sub-module retire_classify: purely combinational decoder producing class, size, mem, data from instr/alu/data inputs.

Test Plan:
- Single ADDI (0x00500093) at pc 0x0, trc_rdy_i=1 → next cycle trc_vld_o=1, class 0, rd 1, data = wb_data 5, seq 0; trc_vld_o=0 the following cycle.
- LW x2,4(x0) with alu 0x2004, ldata 0xDEADBEEF → class 2, size 001, mem 001, addr 0x004, data 0xDEADBEEF.
- SB to alu 0x7000, sdata 0xAB → class 3, size 100, mem 010. BEQ → class 1, data 0.
- trc_rdy_i=0, 10 consecutive retires with DEPTH=8 → full_o after 8th, ovf_cnt_o=2. Then drain gives seq 0..7 in order; next retire gets seq 10.
- Full FIFO, retire and pop same cycle → count stays 8, ovf_cnt_o unchanged, new record at tail.
- rst_ni low mid-burst with 5 records buffered → trc_vld_o=0 immediately, seq and ovf restart at 0. With TRACE_STALL_EN, stall_o rises when count reaches 7.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and decode constants for the retirement trace buffer
package trace_pkg;

    typedef enum logic [2:0] {
        CLS_DEFAULT = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4
    } trace_class_e;

    // Access size, one-hot
    localparam logic [2:0] SZ_NONE = 3'b000;
    localparam logic [2:0] SZ_W    = 3'b001;
    localparam logic [2:0] SZ_H    = 3'b010;
    localparam logic [2:0] SZ_B    = 3'b100;

    // Memory region match values on upper ALU address bits
    localparam logic [2:0]  REG0_HI = 3'b001;
    localparam logic [9:0]  REG1_HI = 10'b0111000000;
    localparam logic [10:0] REG2_HI = 11'b01111000000;

    // RV32 major opcodes
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0]  seq;
        logic [31:0]  pc;
        logic [31:0]  instr;
        logic [4:0]   rd;
        logic [31:0]  data;
        logic [11:0]  addr;
        trace_class_e cls;
        logic [2:0]   size;
        logic [2:0]   mem;
    } trace_rec_t;

    // funct3[1:0] of a load/store encodes byte/half/word
    function automatic logic [2:0] ls_size(input logic [1:0] funct);
        case (funct)
            2'b00:   ls_size = SZ_B;
            2'b01:   ls_size = SZ_H;
            2'b10:   ls_size = SZ_W;
            default: ls_size = SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/retire_classify.sv
// rtl/retire_classify.sv - combinational classifier for one retirement record
module retire_classify
    import trace_pkg::*;
(
    input  logic [6:0]   opcode_i,
    input  logic [1:0]   funct_i,
    input  logic [15:0]  alu_i,
    input  logic [31:0]  wb_data_i,
    input  logic [31:0]  ldata_i,
    input  logic [31:0]  sdata_i,
    output trace_class_e class_o,
    output logic [2:0]   size_o,
    output logic [2:0]   mem_o,
    output logic [31:0]  data_o
);

    // Priority decode: branch > load > store > jump > default
    always_comb begin
        class_o = CLS_DEFAULT;
        size_o  = SZ_NONE;
        data_o  = wb_data_i;
        if (opcode_i == OP_BRANCH) begin
            class_o = CLS_BRANCH;
            data_o  = '0;
        end else if (opcode_i == OP_LOAD) begin
            class_o = CLS_LOAD;
            size_o  = ls_size(funct_i);
            data_o  = ldata_i;
        end else if (opcode_i == OP_STORE) begin
            class_o = CLS_STORE;
            size_o  = ls_size(funct_i);
            data_o  = sdata_i;
        end else if (opcode_i == OP_JAL || opcode_i == OP_JALR || opcode_i == OP_AUIPC) begin
            class_o = CLS_JUMP;
        end
    end

    assign mem_o = {alu_i[15:5] == REG2_HI, alu_i[15:6] == REG1_HI, alu_i[15:13] == REG0_HI};

endmodule

// File: rtl/retire_trace_buf.sv
// rtl/retire_trace_buf.sv - lossy retirement trace FIFO; TRACE_STALL_EN adds early backpressure
module retire_trace_buf
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             retire_vld_i,
    input  logic [31:0]      retire_pc_i,
    input  logic [31:0]      retire_instr_i,
    input  logic [31:0]      retire_wb_data_i,
    input  logic [31:0]      retire_alu_i,
    input  logic [31:0]      retire_ldata_i,
    input  logic [31:0]      retire_sdata_i,
    output logic             trc_vld_o,
    input  logic             trc_rdy_i,
    output logic [31:0]      trc_seq_o,
    output logic [31:0]      trc_pc_o,
    output logic [31:0]      trc_instr_o,
    output logic [4:0]       trc_rd_o,
    output logic [31:0]      trc_data_o,
    output logic [11:0]      trc_addr_o,
    output logic [2:0]       trc_class_o,
    output logic [2:0]       trc_size_o,
    output logic [2:0]       trc_mem_o,
    output logic [CNT_W-1:0] ovf_cnt_o,
    output logic             full_o,
    output logic             stall_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      seq_q;
    logic [CNT_W-1:0] ovf_q;
    trace_rec_t       buf_q [DEPTH];
    trace_rec_t       rec, head;
    trace_class_e     cls;
    logic [2:0]       size, mem;
    logic [31:0]      data;
    logic             full, pop, push, drop;
    logic             unused_bits;

    assign unused_bits = ^{retire_alu_i[31:16], retire_instr_i[14]};

    retire_classify u_classify (
        .opcode_i  (retire_instr_i[6:0]),
        .funct_i   (retire_instr_i[13:12]),
        .alu_i     (retire_alu_i[15:0]),
        .wb_data_i (retire_wb_data_i),
        .ldata_i   (retire_ldata_i),
        .sdata_i   (retire_sdata_i),
        .class_o   (cls),
        .size_o    (size),
        .mem_o     (mem),
        .data_o    (data)
    );

    always_comb begin
        rec       = '0;
        rec.seq   = seq_q;
        rec.pc    = retire_pc_i;
        rec.instr = retire_instr_i;
        rec.rd    = retire_instr_i[11:7];
        rec.data  = data;
        rec.addr  = retire_alu_i[11:0];
        rec.cls   = cls;
        rec.size  = size;
        rec.mem   = mem;
    end

    assign full = (count_q == CNT_FULL);
    assign pop  = trc_vld_o && trc_rdy_i;
    assign push = retire_vld_i && (!full || pop);
    assign drop = retire_vld_i && full && !pop;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Async-assert, sync-deassert local reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    // Pointers, occupancy, sequence and drop counters
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            seq_q   <= '0;
            ovf_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            if (retire_vld_i) seq_q <= seq_q + 32'd1;
            if (drop && ovf_q != '1) ovf_q <= ovf_q + CNT_W'(1);
        end
    end

    // Record storage; contents are masked while empty so needs no reset
    always_ff @(posedge clk_i) begin
        if (push) buf_q[wr_q] <= rec;
    end

`ifdef TRACE_STALL_EN
    logic stall_q;

    // Raise stall as soon as only one free slot remains after this cycle
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (count_d >= (PTR_W+1)'(DEPTH - 1));
        end
    end
    assign stall_o = stall_q;
`else
    assign stall_o = 1'b0;
`endif

    assign trc_vld_o   = (count_q != '0);
    assign head        = trc_vld_o ? buf_q[rd_q] : '0;
    assign trc_seq_o   = head.seq;
    assign trc_pc_o    = head.pc;
    assign trc_instr_o = head.instr;
    assign trc_rd_o    = head.rd;
    assign trc_data_o  = head.data;
    assign trc_addr_o  = head.addr;
    assign trc_class_o = head.cls;
    assign trc_size_o  = head.size;
    assign trc_mem_o   = head.mem;
    assign ovf_cnt_o   = ovf_q;
    assign full_o      = full;

endmodule

// File: tb/tb_retire_trace_buf.sv
// tb/tb_retire_trace_buf.sv - randomized self-checking bench for retire_trace_buf
module tb_retire_trace_buf;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             retire_vld_i = 1'b0;
    logic [31:0]      retire_pc_i = '0, retire_instr_i = '0, retire_wb_data_i = '0;
    logic [31:0]      retire_alu_i = '0, retire_ldata_i = '0, retire_sdata_i = '0;
    logic             trc_vld_o, trc_rdy_i = 1'b0;
    logic [31:0]      trc_seq_o, trc_pc_o, trc_instr_o, trc_data_o;
    logic [4:0]       trc_rd_o;
    logic [11:0]      trc_addr_o;
    logic [2:0]       trc_class_o, trc_size_o, trc_mem_o;
    logic [CNT_W-1:0] ovf_cnt_o;
    logic             full_o, stall_o;

    retire_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .retire_vld_i(retire_vld_i),
        .retire_pc_i(retire_pc_i), .retire_instr_i(retire_instr_i),
        .retire_wb_data_i(retire_wb_data_i), .retire_alu_i(retire_alu_i),
        .retire_ldata_i(retire_ldata_i), .retire_sdata_i(retire_sdata_i),
        .trc_vld_o(trc_vld_o), .trc_rdy_i(trc_rdy_i), .trc_seq_o(trc_seq_o),
        .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_rd_o(trc_rd_o),
        .trc_data_o(trc_data_o), .trc_addr_o(trc_addr_o), .trc_class_o(trc_class_o),
        .trc_size_o(trc_size_o), .trc_mem_o(trc_mem_o), .ovf_cnt_o(ovf_cnt_o),
        .full_o(full_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] seq, pc, instr, data;
        logic [4:0]  rd;
        logic [11:0] addr;
        logic [2:0]  cls, size, mem;
    } mrec_t;

    mrec_t       q[$];
    logic [31:0] m_seq;
    logic [15:0] m_ovf;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] ins);
        case (ins[6:0])
            7'h63:               return 3'd1;
            7'h03:               return 3'd2;
            7'h23:               return 3'd3;
            7'h6f, 7'h67, 7'h17: return 3'd4;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic mrec_t mk(input logic [31:0] ins, pc, alu, wb, ld, sd);
        mrec_t r;
        int    a;
        r.seq   = m_seq;
        r.pc    = pc;
        r.instr = ins;
        r.rd    = ins[11:7];
        r.addr  = alu[11:0];
        r.cls   = ref_class(ins);
        r.size  = 3'b000;
        if (r.cls == 3'd2 || r.cls == 3'd3) begin
            if (ins[13:12] == 2'd0) r.size = 3'b100;
            else if (ins[13:12] == 2'd1) r.size = 3'b010;
            else if (ins[13:12] == 2'd2) r.size = 3'b001;
        end
        case (r.cls)
            3'd1:    r.data = 32'd0;
            3'd2:    r.data = ld;
            3'd3:    r.data = sd;
            default: r.data = wb;
        endcase
        a = int'(alu[15:0]);
        r.mem[0] = (a >= 'h2000 && a < 'h4000);
        r.mem[1] = (a >= 'h7000 && a < 'h7040);
        r.mem[2] = (a >= 'h7800 && a < 'h7820);
        return r;
    endfunction

    task automatic compare_all();
        mrec_t e;
        e = '{default: '0};
        if (q.size() != 0) e = q[0];
        check("vld", trc_vld_o, q.size() != 0);
        check("full", full_o, q.size() == DEPTH);
        check("ovf", ovf_cnt_o, m_ovf);
`ifdef TRACE_STALL_EN
        check("stall", stall_o, q.size() >= DEPTH - 1);
`else
        check("stall", stall_o, 1'b0);
`endif
        check("seq", trc_seq_o, e.seq);
        check("pc", trc_pc_o, e.pc);
        check("instr", trc_instr_o, e.instr);
        check("rd", trc_rd_o, e.rd);
        check("data", trc_data_o, e.data);
        check("addr", trc_addr_o, e.addr);
        check("class", trc_class_o, e.cls);
        check("size", trc_size_o, e.size);
        check("mem", trc_mem_o, e.mem);
    endtask

    task automatic step(input logic v, input logic [31:0] ins, pc, alu, wb, ld, sd, input logic rdy);
        logic pop, full;
        retire_vld_i = v;   retire_instr_i = ins; retire_pc_i = pc; retire_alu_i = alu;
        retire_wb_data_i = wb; retire_ldata_i = ld; retire_sdata_i = sd; trc_rdy_i = rdy;
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (v) begin
            if (!full || pop) q.push_back(mk(ins, pc, alu, wb, ld, sd));
            else if (m_ovf != 16'hFFFF) m_ovf++;
            m_seq++;
        end
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        retire_vld_i = 1'b0;
        trc_rdy_i = 1'b0;
        #1;
        check("rst_vld", trc_vld_o, 1'b0);
        check("rst_ovf", ovf_cnt_o, '0);
        q.delete();
        m_seq = '0;
        m_ovf = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    logic [6:0] ops [8] = '{7'h13, 7'h63, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h17, 7'h33};

    initial begin
        logic [31:0] ins, alu;
        do_reset();

        step(1'b1, ADDI, 32'h0, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1);
        check("addi_class", trc_class_o, 3'd0);
        check("addi_rd", trc_rd_o, 5'd1);
        check("addi_data", trc_data_o, 32'd5);
        check("addi_seq", trc_seq_o, 32'd0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
        check("addi_gone", trc_vld_o, 1'b0);

        step(1'b1, 32'h00402103, 32'h4, 32'h2004, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1);
        check("lw_class", trc_class_o, 3'd2);
        check("lw_size", trc_size_o, 3'b001);
        check("lw_mem", trc_mem_o, 3'b001);
        check("lw_addr", trc_addr_o, 12'h004);
        check("lw_data", trc_data_o, 32'hDEADBEEF);
        step(1'b1, 32'h00100023, 32'h8, 32'h7000, 32'h0, 32'h0, 32'hAB, 1'b1);
        check("sb_class", trc_class_o, 3'd3);
        check("sb_size", trc_size_o, 3'b100);
        check("sb_mem", trc_mem_o, 3'b010);
        step(1'b1, 32'h00000063, 32'hC, 32'h0, 32'h77, 32'h0, 32'h0, 1'b1);
        check("beq_class", trc_class_o, 3'd1);
        check("beq_data", trc_data_o, 32'd0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);

        // Overflow: ten retires into an 8-deep FIFO with the consumer stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ADDI, 32'(i * 4), 32'h0, 32'(i), 32'h0, 32'h0, 1'b0);
            if (i == 7) check("full_after_8", full_o, 1'b1);
        end
        check("ovf_two", ovf_cnt_o, 16'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain_seq", trc_seq_o, 32'(i));
            step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
        end
        step(1'b1, ADDI, 32'h100, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0);
        check("seq_after_gap", trc_seq_o, 32'd10);
        for (int i = 0; i < 7; i++) step(1'b1, ADDI, 32'h200 + 32'(i), 32'h0, 32'h2, 32'h0, 32'h0, 1'b0);
        step(1'b1, ADDI, 32'h300, 32'h0, 32'h3, 32'h0, 32'h0, 1'b1);
        check("full_pushpop_full", full_o, 1'b1);
        check("full_pushpop_ovf", ovf_cnt_o, 16'd2);
        check("full_pushpop_head", trc_seq_o, 32'd11);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);

        // Reset with records buffered
        for (int i = 0; i < 5; i++) step(1'b1, ADDI, 32'(i), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        do_reset();
        step(1'b1, ADDI, 32'h40, 32'h0, 32'h9, 32'h0, 32'h0, 1'b1);
        check("seq_restart", trc_seq_o, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 7)];
            alu = $urandom();
            case ($urandom_range(0, 3))
                1: alu[15:0] = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
                2: alu[15:0] = 16'h7000 | 16'($urandom_range(0, 16'h7F));
                3: alu[15:0] = 16'h7800 | 16'($urandom_range(0, 16'h3F));
                default: ;
            endcase
            step($urandom_range(0, 9) < 7, ins, $urandom(), alu, $urandom(), $urandom(), $urandom(),
                 $urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 5 : 8));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
